// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// Operand/result handshake bundle; master is the requester/consumer side, slave is the adder controller.
interface rca_seq_ctrl_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/rca.sv
// 4-bit ripple-carry adder, purely combinational.
// Latency 0; no flow control.
module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

// File: rtl/rca_seq_ctrl.sv
// Full-width add built from one shared 4-bit ripple adder, one nibble per cycle, LSB first.
// Latency: out_valid rises WIDTH/4 cycles after accept; result holds until out_ready, new operands may be taken on the same edge.
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    rca_seq_ctrl_if.slave   bus
);
    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_d, sum_q;
    logic               carry_q, cout_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
    logic               nib_co;
    logic               in_ready_c, out_valid_c, accept, last;

    assign nib_a = a_q[idx_q*NIB_W +: NIB_W];
    assign nib_b = b_q[idx_q*NIB_W +: NIB_W];
    assign last  = (idx_q == LAST_IDX);

    rca u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_s),
        .cout (nib_co)
    );

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        acc_d       = acc_q;
        acc_d[idx_q*NIB_W +: NIB_W] = nib_s;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                // Releasing the result and taking new operands share one edge.
                if (bus.out_ready) state_d = bus.in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = bus.in_valid & in_ready_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                carry_q <= bus.cin;
                idx_q   <= '0;
            end else if (state_q == RUN) begin
                acc_q   <= acc_d;
                carry_q <= nib_co;
                idx_q   <= last ? '0 : idx_q + 1'b1;
                // Partial nibbles stay in acc_q; sum only changes once complete.
                if (last) begin
                    sum_q  <= acc_d;
                    cout_q <= nib_co;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed scoreboard bench for rca_seq_ctrl at WIDTH=16.
module tb_rca_seq_ctrl;
    localparam int W   = 16;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_results = 0;

    logic [W:0] exp_q[$];
    int         acc_cyc_q[$];

    rca_seq_ctrl_if #(.WIDTH(W)) bus ();

    rca_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: latency on each out_valid rise, data on each result handshake.
    initial begin : monitor
        logic prev_ov;
        int   acc_c;
        logic [W:0] e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.out_valid && !prev_ov) begin
                    if (acc_cyc_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
                    else begin
                        acc_c = acc_cyc_q.pop_front();
                        check("latency", 32'(cyc - acc_c), 32'(LAT));
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("sum",  32'(bus.sum),  32'(e[W-1:0]));
                        check("cout", 32'(bus.cout), 32'(e[W]));
                        n_results++;
                    end
                end
            end
            prev_ov = bus.out_valid & ~rst;
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic push, input logic [W:0] expv);
        logic done;
        done = 1'b0;
        bus.a = av; bus.b = bv; bus.cin = ci; bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        if (push && done) begin
            exp_q.push_back(expv);
            acc_cyc_q.push_back(cyc);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic saw_valid;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        @(posedge clk); #1;

        send(16'h0001, 16'h0001, 1'b0, 1'b1, {1'b0, 16'h0002});
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, {1'b1, 16'h0000});
        drain();
        send(16'h5555, 16'h5555, 1'b1, 1'b1, {1'b0, 16'hAAAB});
        drain();

        // Stall in DONE with a stray in_valid pulse, then chain a new op on release.
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, 1'b1, {1'b0, 16'h5555});
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1; bus.in_valid = 1'b1;
            end else bus.in_valid = 1'b0;
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_sum",       32'(bus.sum),       32'h5555);
            check("stall_cout",      32'(bus.cout),      32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        send(16'h000E, 16'h0001, 1'b1, 1'b1, {1'b0, 16'h0010});
        drain();

        // Reset while in RUN with idx==2.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, '0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rrst_sum",       32'(bus.sum),       32'd0);
        check("rrst_cout",      32'(bus.cout),      32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("rrst_no_valid", 32'(saw_valid), 32'd0);

        repeat (2) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("n_results",   32'(n_results),    32'd5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
